// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan controller.
// Channel count, select width and FSM state encodings.
package mux_scan_ctrl_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_HOLD   = ST_HOLD
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Sample stream from the scan controller to its consumer.
// valid/ready handshake carrying the captured word and its channel.
interface mux_scan_ctrl_if
  import mux_scan_ctrl_pkg::*;
#(
  parameter int W = 4
);

  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mux_next_ch.sv
// Channel pick logic for the scan sequencer.
// Rotating next pick above cur, plus lowest/highest set bit of mask.
module mux_next_ch
  import mux_scan_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] nxt,
  output logic [SEL_W-1:0] first,
  output logic [SEL_W-1:0] last,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  assign any = |mask;

  // i runs to NCH so a lone set bit at cur picks itself again
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= NCH; i++) begin
      idx = SEL_W'((int'(cur) + i) % NCH);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    first = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
    end
  end

  always_comb begin
    last = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) last = SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer and capture stage around a 4:1 mux.
// Settles each enabled channel, captures it and offers it downstream.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   ch_mask,
  output logic [SEL_W-1:0] s,
  input  logic [W-1:0]     o_in,
  mux_scan_ctrl_if.master  bus,
  output logic             sweep_done,
  output logic             busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           st_q, st_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [SEL_W-1:0] nxt, first, last;
  logic             any;
  logic             hs;

  mux_next_ch u_next (
    .cur   (s_q),
    .mask  (ch_mask),
    .nxt   (nxt),
    .first (first),
    .last  (last),
    .any   (any)
  );

  assign hs = valid_q && bus.out_ready;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ch_d    = ch_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (en && any) begin
          s_d   = first;
          cnt_d = CNT_INIT;
          st_d  = S_SETTLE;
        end
      end
      // channel is committed here; en/mask changes cannot abort it
      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = o_in;
          ch_d    = s_q;
          valid_d = 1'b1;
          st_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hs) begin
          valid_d = 1'b0;
          done_d  = any && (ch_q == last);
          if (en && any) begin
            s_d   = nxt;
            cnt_d = CNT_INIT;
            st_d  = S_SETTLE;
          end else begin
            st_d  = S_IDLE;
          end
        end
      end
      default: begin
        st_d    = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign s             = s_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign sweep_done    = done_q;
  assign busy          = (st_q != S_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a one-hot mux model.
// Scoreboard queue of expected (channel, last-of-sweep) per transfer.
module tb_mux_scan_ctrl;

  typedef struct {
    logic [1:0] ch;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en, en3;
  logic [3:0] ch_mask;
  logic [1:0] s1, s3;
  logic [3:0] o1, o3;
  logic       done1, done3;
  logic       busy1, busy3;

  int   checks;
  int   errors;
  int   cyc;
  int   hs_last, hs_prev;
  bit   run;
  bit   pend;
  logic pend_exp;
  exp_t q[$];

  mux_scan_ctrl_if #(.W(4)) bus1 ();
  mux_scan_ctrl_if #(.W(4)) bus3 ();

  // mux_2s stand-in: d0=1, d1=2, d2=4, d3=8
  assign o1 = 4'b0001 << s1;
  assign o3 = 4'b0001 << s3;

  mux_scan_ctrl #(.W(4), .SETTLE(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_mask    (ch_mask),
    .s          (s1),
    .o_in       (o1),
    .bus        (bus1),
    .sweep_done (done1),
    .busy       (busy1)
  );

  mux_scan_ctrl #(.W(4), .SETTLE(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .en         (en3),
    .ch_mask    (4'hF),
    .s          (s3),
    .o_in       (o3),
    .bus        (bus3),
    .sweep_done (done3),
    .busy       (busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic last);
    exp_t e;
    e.ch   = ch;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      if (q.size() == 1 && bus1.out_valid) en = 1'b0;
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // handshake and sweep_done monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 1'b0;
    end else if (run) begin
      chk("sweep_done", 32'(done1), 32'(pend ? pend_exp : 1'b0));
      pend = 1'b0;
      if (bus1.out_valid && bus1.out_ready) begin
        if (q.size() == 0) begin
          chk("extra_xfer", 32'(bus1.out_ch), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("xfer_ch", 32'(bus1.out_ch), 32'(e.ch));
          chk("xfer_data", 32'(bus1.out_data), 32'(4'b0001 << e.ch));
          pend     = 1'b1;
          pend_exp = e.last;
          hs_prev  = hs_last;
          hs_last  = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    hs_last = 0;
    hs_prev = 0;
    run     = 1'b0;
    pend    = 1'b0;
    rst     = 1'b1;
    en      = 1'b1;
    en3     = 1'b0;
    ch_mask = 4'hF;
    bus1.out_ready = 1'b1;
    bus3.out_ready = 1'b1;

    // reset held with en high
    tick();
    tick();
    chk("rst_s", 32'(s1), 32'd0);
    chk("rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst3_valid", 32'(bus3.out_valid), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);

    // full scan, one sweep plus wrap to ch 0
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b1);
    push(2'd0, 1'b0);
    rst = 1'b0;
    run = 1'b1;
    drain(40);
    chk("thru_cycles", 32'(hs_last - hs_prev), 32'd2);
    tick();
    chk("full_idle", 32'(busy1), 32'd0);

    // sparse mask with wrap
    ch_mask = 4'b1010;
    push(2'd1, 1'b0);
    push(2'd3, 1'b1);
    push(2'd1, 1'b0);
    push(2'd3, 1'b1);
    en = 1'b1;
    drain(40);

    // single channel repeats
    ch_mask = 4'b0100;
    push(2'd2, 1'b1);
    push(2'd2, 1'b1);
    push(2'd2, 1'b1);
    en = 1'b1;
    drain(40);

    // backpressure while holding ch 1
    ch_mask = 4'hF;
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    en = 1'b1;
    n  = 0;
    while (!(bus1.out_valid && bus1.out_ch == 2'd1) && n < 20) begin
      tick();
      n++;
    end
    chk("bp_reach", 32'(n < 20), 32'd1);
    bus1.out_ready = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus1.out_valid), 32'd1);
      chk("bp_data", 32'(bus1.out_data), 32'd2);
      chk("bp_ch", 32'(bus1.out_ch), 32'd1);
      chk("bp_s", 32'(s1), 32'd1);
      tick();
    end
    bus1.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus1.out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy1), 32'd0);
    chk("bp_one_xfer", 32'(q.size()), 32'd0);

    // stop during settle of ch 2, also clearing its mask bit
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    en = 1'b1;
    n  = 0;
    while (!(busy1 && !bus1.out_valid && s1 == 2'd2) && n < 20) begin
      tick();
      n++;
    end
    chk("stop_reach", 32'(n < 20), 32'd1);
    en      = 1'b0;
    ch_mask = 4'b1011;
    drain(20);
    tick();
    chk("stop_busy", 32'(busy1), 32'd0);
    chk("stop_valid", 32'(bus1.out_valid), 32'd0);

    // empty mask keeps it idle
    ch_mask = 4'h0;
    en      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mask0_busy", 32'(busy1), 32'd0);
    end

    // reset while holding a valid word
    bus1.out_ready = 1'b0;
    ch_mask = 4'hF;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("hold_reach", 32'(bus1.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus1.out_valid), 32'd0);
    chk("midrst_s", 32'(s1), 32'd0);
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    rst = 1'b0;
    en  = 1'b0;
    tick();

    // latency: SETTLE=1 -> 2 edges, SETTLE=3 -> 4 edges
    bus1.out_ready = 1'b1;
    push(2'd0, 1'b0);
    en  = 1'b1;
    en3 = 1'b1;
    tick();
    chk("lat1_e1", 32'(bus1.out_valid), 32'd0);
    chk("lat3_e1", 32'(bus3.out_valid), 32'd0);
    tick();
    chk("lat1_e2", 32'(bus1.out_valid), 32'd1);
    chk("lat3_e2", 32'(bus3.out_valid), 32'd0);
    en = 1'b0;
    tick();
    chk("lat3_e3", 32'(bus3.out_valid), 32'd0);
    tick();
    chk("lat3_e4", 32'(bus3.out_valid), 32'd1);
    chk("lat3_ch", 32'(bus3.out_ch), 32'd0);
    chk("lat3_data", 32'(bus3.out_data), 32'd1);
    en3 = 1'b0;
    drain(10);
    tick();
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
